bin2bcd_disp: RTL and testbench



---
 rtl/bin2bcd_disp.sv | 124 ++++++++++++
 tb/tb_bin2bcd_disp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_disp.sv
// bin2bcd_disp: serial binary-to-BCD converter (double-dabble, one bit per clock)
// feeding the 8-digit 7-segment driver's 32-bit display register.
// A 9th BCD digit is kept internally only to flag values above 99,999,999.
// Optional build macro: BCD_SAT_EN -- when defined, an overflowing value shows
// as 99999999 instead of wrapping modulo 100,000,000.
module bin2bcd_disp #(
    parameter int BIN_WIDTH = 27
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARSTN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [BIN_WIDTH-1:0] IN_DATA,
    output logic                 OUT_VALID,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_OVF
);

    // 4..29 bits: the lower bound keeps the counter meaningful, the upper
    // bound keeps every input below 10^9 so nine digits always suffice.
    if (BIN_WIDTH < 4 || BIN_WIDTH > 29) begin : g_cfg_err
        $error("bin2bcd_disp: BIN_WIDTH must be in 4..29");
    end

    localparam int              CNT_W    = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] sr_q, sr_d;
    logic [35:0]          acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;
    logic                 out_ovf_q, out_ovf_d;
    logic [35:0]          acc_adj;
    logic                 ovf;

    // Add 3 to every digit >= 5, each nibble independent (no inter-digit carry).
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            acc_adj[i*4 +: 4] = (acc_q[i*4 +: 4] >= 4'd5) ? acc_q[i*4 +: 4] + 4'd3
                                                          : acc_q[i*4 +: 4];
        end
    end

    assign ovf = (acc_q[35:32] != 4'd0);

    // Next-state logic for the IDLE -> CONV -> DONE sequence.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    sr_d    = IN_DATA;
                    acc_d   = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // Binary MSB moves into the accumulator LSB on each shift.
                {acc_d, sr_d} = {acc_adj, sr_q} << 1;
                cnt_d         = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_ovf_d   = ovf;
`ifdef BCD_SAT_EN
                out_data_d  = ovf ? 32'h9999_9999 : acc_q[31:0];
`else
                out_data_d  = acc_q[31:0];
`endif
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_OVF   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Testbench for bin2bcd_disp (BIN_WIDTH=27): directed conversions checked via a
// scoreboard of decimal-model results, plus latency, back-to-back and reset-abort cases.
module tb_bin2bcd_disp;

    localparam int BW = 27;

    logic          S_AXI_ACLK;
    logic          S_AXI_ARSTN;
    logic          IN_VALID;
    logic          IN_READY;
    logic [BW-1:0] IN_DATA;
    logic          OUT_VALID;
    logic [31:0]   OUT_DATA;
    logic          OUT_OVF;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [32:0] sb[$];

    bin2bcd_disp #(.BIN_WIDTH(BW)) dut (
        .S_AXI_ACLK (S_AXI_ACLK),
        .S_AXI_ARSTN(S_AXI_ARSTN),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_DATA    (IN_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_DATA   (OUT_DATA),
        .OUT_OVF    (OUT_OVF)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {ovf, display} computed by decimal division.
    function automatic logic [32:0] model(input longint v);
        longint      m;
        logic [31:0] d;
        logic        o;
        m = v % 100000000;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        o = (v > 99999999);
`ifdef BCD_SAT_EN
        if (o) d = 32'h9999_9999;
`endif
        return {o, d};
    endfunction

    // Scoreboard consumer: every OUT_VALID pulse must match the oldest pending result.
    always @(negedge S_AXI_ACLK) begin
        if (S_AXI_ARSTN && OUT_VALID) begin
            logic [32:0] e;
            check("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", 64'(OUT_DATA), 64'(e[31:0]));
                check("out_ovf", 64'(OUT_OVF), 64'(e[32]));
            end
        end
    end

    // One conversion with latency, busy-time and pulse-width checks.
    task automatic run_conv(input longint v);
        int j;
        int busy;
        bit seen;
        @(negedge S_AXI_ACLK);
        check("ready_before", 64'(IN_READY), 64'd1);
        IN_VALID = 1'b1;
        IN_DATA  = BW'(v);
        sb.push_back(model(v));
        @(posedge S_AXI_ACLK);
        #1;
        IN_VALID = 1'b0;
        IN_DATA  = '1;
        busy = 0;
        seen = 1'b0;
        for (j = 0; j < 60 && !seen; j++) begin
            @(negedge S_AXI_ACLK);
            if (!IN_READY) busy++;
            if (OUT_VALID) seen = 1'b1;
        end
        check("out_valid_seen", 64'(seen), 64'd1);
        check("latency_edges", 64'(j), 64'd29);
        check("busy_cycles", 64'(busy), 64'd28);
        @(negedge S_AXI_ACLK);
        check("pulse_one_cycle", 64'(OUT_VALID), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t1;
        int t2;
        bit seen;

        S_AXI_ARSTN = 1'b0;
        IN_VALID    = 1'b0;
        IN_DATA     = '0;
        #1;
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_out_data", 64'(OUT_DATA), 64'd0);
        check("rst_out_ovf", 64'(OUT_OVF), 64'd0);
        repeat (2) @(negedge S_AXI_ACLK);
        S_AXI_ARSTN = 1'b1;

        run_conv(0);
        run_conv(12345678);
        run_conv(99999999);
        run_conv(100000000);
        run_conv(134217727);
        run_conv(1);
        run_conv(134217727);

        // Back-to-back: IN_VALID held high, 42 offered while 5 converts.
        @(negedge S_AXI_ACLK);
        IN_VALID = 1'b1;
        IN_DATA  = BW'(5);
        sb.push_back(model(5));
        @(posedge S_AXI_ACLK);
        #1;
        IN_DATA = BW'(42);
        sb.push_back(model(42));
        seen = 1'b0;
        t1 = 0;
        for (int j = 0; j < 60 && !seen; j++) begin
            @(negedge S_AXI_ACLK);
            if (OUT_VALID) begin
                seen = 1'b1;
                t1 = cyc;
                check("b2b_ready_with_valid", 64'(IN_READY), 64'd1);
            end
        end
        check("b2b_first_seen", 64'(seen), 64'd1);
        @(posedge S_AXI_ACLK);
        #1;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        check("b2b_second_accepted", 64'(IN_READY), 64'd0);
        seen = 1'b0;
        t2 = 0;
        for (int j = 0; j < 60 && !seen; j++) begin
            @(negedge S_AXI_ACLK);
            if (OUT_VALID) begin
                seen = 1'b1;
                t2 = cyc;
            end
        end
        check("b2b_second_seen", 64'(seen), 64'd1);
        check("b2b_pulse_spacing", 64'(t2 - t1), 64'd29);

        // Put OVF/DATA into a non-reset state, then abort a conversion of 777.
        run_conv(134217727);
        @(negedge S_AXI_ACLK);
        IN_VALID = 1'b1;
        IN_DATA  = BW'(777);
        @(posedge S_AXI_ACLK);
        #1;
        IN_VALID = 1'b0;
        repeat (10) @(posedge S_AXI_ACLK);
        #2;
        check("abort_busy", 64'(IN_READY), 64'd0);
        S_AXI_ARSTN = 1'b0;
        #1;
        check("abort_in_ready", 64'(IN_READY), 64'd1);
        check("abort_out_valid", 64'(OUT_VALID), 64'd0);
        check("abort_out_data", 64'(OUT_DATA), 64'd0);
        check("abort_out_ovf", 64'(OUT_OVF), 64'd0);
        repeat (3) @(negedge S_AXI_ACLK);
        S_AXI_ARSTN = 1'b1;
        // Any stray pulse here hits the empty scoreboard.
        repeat (40) @(negedge S_AXI_ACLK);
        check("abort_no_output", 64'(OUT_DATA), 64'd0);
        run_conv(9);

        repeat (2) @(negedge S_AXI_ACLK);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
